// File: rtl/cpu_wb_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : lc3b_types                                             |
// | Description : Shared LC-3b widths and the CPU/Wishbone bridge state  |
// |               encoding.                                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package lc3b_types;

  // CPU word and write byte-mask of the LC-3b memory port
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_wb_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : cpu_wb_bridge_if                                       |
// | Description : Line-wide Wishbone bus between the CPU bridge (master) |
// |               and the cache (slave).                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface cpu_wb_bridge_if #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 16
);

  logic                    wb_cyc;
  logic                    wb_stb;
  logic                    wb_we;
  logic [LINE_BYTES-1:0]   wb_sel;
  logic [ADDR_W-1:0]       wb_adr;
  logic [8*LINE_BYTES-1:0] wb_dat_m;
  logic [8*LINE_BYTES-1:0] wb_dat_s;
  logic                    wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_m,
    input  wb_dat_s, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_m,
    output wb_dat_s, wb_ack
  );

endinterface
`default_nettype wire

// File: rtl/cpu_wb_bridge_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_line_buffer                                        |
// | Description : One-line read buffer: valid/tag/line storage with hit |
// |               compare, word extract, line load, byte merge, flush.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpu_line_buffer #(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 16,
  parameter int OFF        = $clog2(LINE_BYTES),
  parameter int WOFF       = $clog2(WORD_BYTES),
  parameter int IDX_W      = (OFF > WOFF) ? (OFF - WOFF) : 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    flush,
  // lookup side (current CPU address)
  input  wire logic [ADDR_W-OFF-1:0]   lookup_tag,
  input  wire logic [IDX_W-1:0]        lookup_idx,
  output logic                         lookup_hit,
  output logic [8*WORD_BYTES-1:0]      lookup_word,
  // update side (latched bus address)
  input  wire logic [ADDR_W-OFF-1:0]   wr_tag,
  input  wire logic                    load_en,
  input  wire logic [8*LINE_BYTES-1:0] load_line,
  input  wire logic                    merge_en,
  input  wire logic [LINE_BYTES-1:0]   merge_sel,
  input  wire logic [8*LINE_BYTES-1:0] merge_line
);

  localparam int c_word_bits = 8 * WORD_BYTES;

  logic                      r_valid;
  logic [ADDR_W-OFF-1:0]     r_tag;
  logic [8*LINE_BYTES-1:0]   r_line;
  logic [8*LINE_BYTES-1:0]   w_merged;
  logic                      w_wr_match;
  logic [IDX_W+WOFF+2:0]     w_bit_sh;

  assign lookup_hit  = r_valid && (r_tag == lookup_tag);
  assign w_wr_match  = r_valid && (r_tag == wr_tag);
  assign w_bit_sh    = {lookup_idx, {(WOFF + 3){1'b0}}};
  assign lookup_word = r_line[w_bit_sh +: c_word_bits];

  // Per-lane merge: selected lanes take the written bytes, others keep the line
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_merge
    assign w_merged[8*b +: 8] = merge_sel[b] ? merge_line[8*b +: 8] : r_line[8*b +: 8];
  end

  // Line storage: fill on read ack, write-through merge on matching write; flush wins on valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_line  <= '0;
    end else begin
      if (load_en) begin
        r_line  <= load_line;
        r_tag   <= wr_tag;
        r_valid <= 1'b1;
      end else if (merge_en && w_wr_match) begin
        r_line  <= w_merged;
      end
      if (flush) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_wb_bridge                                          |
// | Description : LC-3b word memory port to line-wide Wishbone bridge   |
// |               with registered bus cycles and a one-line read buffer. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cpu_wb_bridge
  import lc3b_types::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    mem_read,
  input  wire logic                    mem_write,
  input  wire logic [WORD_BYTES-1:0]   mem_byte_enable,
  input  wire logic [ADDR_W-1:0]       mem_address,
  input  wire logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [8*WORD_BYTES-1:0]      mem_rdata,
  output logic                         mem_resp,
  input  wire logic                    flush,
  cpu_wb_bridge_if.master              wb
);

  localparam int c_off        = $clog2(LINE_BYTES);
  localparam int c_woff       = $clog2(WORD_BYTES);
  localparam int c_idx_w      = (c_off > c_woff) ? (c_off - c_woff) : 1;
  localparam int c_word_bits  = 8 * WORD_BYTES;
  localparam int c_line_bits  = 8 * LINE_BYTES;

  bridge_state_t               r_state;
  bridge_state_t               w_next_state;
  logic [ADDR_W-1:0]           r_addr;
  logic [c_word_bits-1:0]      r_wdata;
  logic [WORD_BYTES-1:0]       r_mask;
  logic                        r_we;
  logic [c_word_bits-1:0]      r_rdata;

  logic                        w_in_bus;
  logic                        w_accept;
  logic                        w_hit;
  logic [c_word_bits-1:0]      w_buf_word;
  logic [c_idx_w-1:0]          w_cur_idx;
  logic [c_idx_w-1:0]          w_r_idx;
  logic [c_idx_w+c_woff-1:0]   w_byte_sh;
  logic [c_idx_w+c_woff+2:0]   w_bit_sh;
  logic [WORD_BYTES-1:0]       w_word_lanes;
  logic [LINE_BYTES-1:0]       w_sel_line;
  logic [c_line_bits-1:0]      w_dat_line;
  logic [c_word_bits-1:0]      w_fill_word;
  logic                        w_rd_ack;
  logic                        w_wr_ack;

  // Word index within the line, for the live CPU address and the latched one
  if (c_off > c_woff) begin : g_idx
    assign w_cur_idx = mem_address[c_off-1:c_woff];
    assign w_r_idx   = r_addr[c_off-1:c_woff];
  end else begin : g_idx_single
    assign w_cur_idx = '0;
    assign w_r_idx   = '0;
  end

  // Byte-within-word address bits carry no information for word-aligned access
  if (c_woff > 0) begin : g_word_lsb
    logic w_unused_lsb;
    assign w_unused_lsb = ^{mem_address[c_woff-1:0], r_addr[c_woff-1:0]};
  end

  assign w_in_bus     = (r_state == BUS);
  assign w_accept     = (r_state == IDLE) && (mem_read || mem_write);
  assign w_byte_sh    = {w_r_idx, {c_woff{1'b0}}};
  assign w_bit_sh     = {w_r_idx, {(c_woff + 3){1'b0}}};
  assign w_word_lanes = r_we ? r_mask : {WORD_BYTES{1'b1}};
  assign w_sel_line   = LINE_BYTES'(w_word_lanes) << w_byte_sh;
  assign w_dat_line   = c_line_bits'(r_wdata) << w_bit_sh;
  assign w_fill_word  = wb.wb_dat_s[w_bit_sh +: c_word_bits];
  assign w_rd_ack     = w_in_bus && wb.wb_ack && !r_we;
  assign w_wr_ack     = w_in_bus && wb.wb_ack && r_we;

  // Bus outputs decode only from registered state and latched request
  assign wb.wb_cyc   = w_in_bus;
  assign wb.wb_stb   = w_in_bus;
  assign wb.wb_we    = w_in_bus && r_we;
  assign wb.wb_sel   = w_in_bus ? w_sel_line : '0;
  assign wb.wb_adr   = {r_addr[ADDR_W-1:c_off], {c_off{1'b0}}};
  assign wb.wb_dat_m = (w_in_bus && r_we) ? w_dat_line : '0;

  assign mem_resp  = (r_state == RESP);
  assign mem_rdata = r_rdata;

  cpu_line_buffer #(
    .LINE_BYTES (LINE_BYTES),
    .WORD_BYTES (WORD_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_line_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .lookup_tag  (mem_address[ADDR_W-1:c_off]),
    .lookup_idx  (w_cur_idx),
    .lookup_hit  (w_hit),
    .lookup_word (w_buf_word),
    .wr_tag      (r_addr[ADDR_W-1:c_off]),
    .load_en     (w_rd_ack),
    .load_line   (wb.wb_dat_s),
    .merge_en    (w_wr_ack),
    .merge_sel   (w_sel_line),
    .merge_line  (w_dat_line)
  );

  // State register; reset abandons any bus cycle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: writes always go to the bus, reads only on a buffer miss
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (mem_write) begin
          w_next_state = BUS;
        end else if (mem_read) begin
          w_next_state = w_hit ? RESP : BUS;
        end
      end
      BUS:     if (wb.wb_ack) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch on leaving IDLE, and read data capture from buffer or bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= mem_address;
        r_wdata <= mem_wdata;
        r_mask  <= mem_byte_enable;
        r_we    <= mem_write;
      end
      if (w_accept && !mem_write && w_hit) begin
        r_rdata <= w_buf_word;
      end else if (w_rd_ack) begin
        r_rdata <= w_fill_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_wb_bridge.md
# cpu_wb_bridge

Parametrised bridge between the LC-3b core's narrow memory port (word read/write with byte mask) and the line-wide Wishbone bus toward the cache. It replaces the direct combinational hookup of the core to the bus with:
- registered, stable bus cycles;
- correct word placement and extraction for any line width;
- a one-line read buffer, so repeated reads within the last fetched line complete without a bus cycle.

It sits inside the CPU top level, between cpu_control/cpu_datapath and the Wishbone master port.

## Interface
- LINE_BYTES, 16: bytes per bus line (power of two, ≥ WORD_BYTES); OFF = log2(LINE_BYTES)
- WORD_BYTES, 2: bytes per CPU word (power of two)
- ADDR_W, 16: address width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  WORD_BYTES  byte mask for writes
- mem_address  in  ADDR_W  byte address, word-aligned
- mem_wdata  in  8*WORD_BYTES  write data
- mem_rdata  out  8*WORD_BYTES  read data; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- flush  in  1  invalidate read buffer
- wb_cyc, wb_stb  out  1  bus cycle / strobe (always equal)
- wb_we  out  1  write cycle
- wb_sel  out  LINE_BYTES  byte lanes
- wb_adr  out  ADDR_W  line address; low OFF bits forced 0
- wb_dat_m  out  8*LINE_BYTES  write line
- wb_dat_s  in  8*LINE_BYTES  read line
- wb_ack  in  1  bus completion

## Operation
- Word index idx = addr[OFF-1:log2(WORD_BYTES)]. Byte shift = idx*WORD_BYTES. Bit shift = 8 × byte shift.
- FSM states:
  - IDLE: sample requests. mem_write (including read+write both high; write wins) → BUS. mem_read with buffer valid and tag == addr[ADDR_W-1:OFF] → RESP (hit). Other reads → BUS.
  - On leaving IDLE, latch address, wdata, mask, and we. Later changes to the CPU inputs are ignored until RESP.
  - BUS: wb_cyc=wb_stb=1 from registers. Read: wb_sel = {WORD_BYTES 1s} << byte shift. Write: wb_sel = mask << byte shift, wb_dat_m = wdata << bit shift, other lanes 0. On wb_ack → RESP.
  - BUS, read ack: capture the line into the buffer, set tag, set valid, and capture the selected word into the rdata register.
  - BUS, write ack: if buffer valid and tag matches, merge the masked bytes into the buffer (write-through).
  - RESP: mem_resp=1 for exactly one cycle, mem_rdata from register (hit: word extracted from buffer at the IDLE→RESP edge) → IDLE.
- The first sampling of a held request happens in the IDLE cycle after RESP. The CPU must drop or change its request on the mem_resp edge.
- flush=1 clears valid at the next edge in any state. A read fill acking in the same cycle leaves valid=0 (flush wins); mem_resp for that read still occurs with correct data.
- Reset (any state): state=IDLE, valid=0, tag=0, all outputs 0. An in-flight bus cycle is abandoned immediately (wb_cyc drops asynchronously), and no mem_resp is issued.

## Timing
- Miss read / write: request seen in cycle 0; wb_cyc rises in cycle 1; wb_ack in cycle k≥1; mem_resp in cycle k+1. Minimum latency 2 cycles to mem_resp.
- Hit read: mem_resp in cycle 1; no bus activity.
- Bus outputs are register-driven (no combinational path from mem_* to wb_*). wb_stb drops in the cycle after wb_ack.
- wb_ack outside BUS is ignored.

## Structure
- Belongs in lc3b_types: the lc3b_word and lc3b_mem_wmask widths (existing), plus a new bridge_state_t enum {IDLE, BUS, RESP}.
- Sub-module cpu_line_buffer holds valid, tag, and line. It provides:
  - hit compare;
  - word extract by idx;
  - full-line load;
  - masked byte merge;
  - flush.
- The FSM and lane shifting stay in cpu_wb_bridge.

## Test plan
- Read miss: addr 0x1236, ack after 3 cycles with line byte 6 = 0x34, byte 7 = 0x12 → wb_adr=0x1230, wb_sel=0x00C0, mem_rdata=0x1234 with mem_resp at cycle 4.
- Hit after miss: read 0x1230 after the test above → mem_resp next cycle, no wb_cyc, rdata = bytes 0/1 of the captured line.
- Write: addr 0x123E, mask 2'b10, wdata 0xAB00 → wb_sel=0x8000, wb_dat_m[127:120]=0xAB, wb_we=1. A following read of 0x123E hits and returns 0xABxx, with low byte unchanged.
- flush and ack in same cycle on a read miss → mem_resp with correct data; a following read of the same line issues a bus cycle.
- rst_n low mid-BUS → wb_cyc=0 immediately, no mem_resp. After release, a read to the prior line misses.
- mem_read and mem_write both high → write cycle (wb_we=1); the CPU inputs change during BUS but the bus outputs stay constant.
